// File: rtl/mul16_pkg.sv
// Shared types and constants for the sequential 16x16 multiplier controller.
package mul16_pkg;

    localparam int unsigned PROD_W = 32;
    localparam int unsigned HALF_W = 8;
    localparam int unsigned OPER_W = 2 * HALF_W;

    localparam int unsigned SHIFT_S0 = 0;
    localparam int unsigned SHIFT_S1 = 8;
    localparam int unsigned SHIFT_S2 = 8;
    localparam int unsigned SHIFT_S3 = 16;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDone
    } state_e;

    function automatic logic [4:0] step_shift(input logic [1:0] step);
        logic [4:0] sh;
        unique case (step)
            2'd0:    sh = 5'(SHIFT_S0);
            2'd1:    sh = 5'(SHIFT_S1);
            2'd2:    sh = 5'(SHIFT_S2);
            default: sh = 5'(SHIFT_S3);
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/mul16_seq_ctrl_multi_8.sv
// multi_8: combinational 8x8 unsigned array multiplier core (shift-and-add rows).
module multi_8
    import mul16_pkg::*;
(
    input  logic [HALF_W-1:0]   a_i,
    input  logic [HALF_W-1:0]   b_i,
    output logic [2*HALF_W-1:0] p_o
);

    always_comb begin
        p_o = '0;
        for (int i = 0; i < HALF_W; i++) begin
            if (b_i[i]) begin
                p_o = p_o + ((2*HALF_W)'(a_i) << i);
            end
        end
    end

endmodule

// File: rtl/mul16_seq_ctrl.sv
// Sequential 16x16 unsigned multiplier: one shared multi_8 core, four partial products.
// Define MUL16_SEQ_MAC_EN to add the in_acc port (accumulate onto the previous result).
module mul16_seq_ctrl
    import mul16_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_a,
    input  logic [15:0]       in_b,
    input  logic [TAG_W-1:0]  in_tag,
`ifdef MUL16_SEQ_MAC_EN
    input  logic              in_acc,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_p,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    state_e              state_q, state_d;
    logic [1:0]          step_q, step_d;
    logic [OPER_W-1:0]   a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [PROD_W-1:0]   acc_base;
    logic [HALF_W-1:0]   core_a, core_b;
    logic [OPER_W-1:0]   core_p;
    logic [PROD_W-1:0]   addend;
    logic                load;

    // Step bit 0 picks the high half of a, bit 1 the high half of b.
    assign core_a = step_q[0] ? a_q[OPER_W-1:HALF_W] : a_q[HALF_W-1:0];
    assign core_b = step_q[1] ? b_q[OPER_W-1:HALF_W] : b_q[HALF_W-1:0];
    assign addend = PROD_W'(core_p) << step_shift(step_q);

    multi_8 u_core (
        .a_i (core_a),
        .b_i (core_b),
        .p_o (core_p)
    );

`ifdef MUL16_SEQ_MAC_EN
    logic [PROD_W-1:0] prev_q, prev_d;

    assign acc_base = in_acc ? prev_q : '0;
    assign prev_d   = (state_q == StMul && step_q == 2'd3) ? acc_d : prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end
`else
    assign acc_base = '0;
`endif

    assign in_ready  = (state_q == StIdle) || (state_q == StDone && out_ready);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StMul);
    assign out_p     = acc_q;
    assign out_tag   = tag_q;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        tag_d   = tag_q;
        acc_d   = acc_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) load = 1'b1;
            end
            StMul: begin
                acc_d  = acc_q + addend;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                    if (in_valid) load = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (load) begin
            state_d = StMul;
            step_d  = 2'd0;
            a_d     = in_a;
            b_d     = in_b;
            tag_d   = in_tag;
            acc_d   = acc_base;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            step_q  <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// Randomized self-checking bench for mul16_seq_ctrl against an arithmetic reference model.
module tb_mul16_seq_ctrl;

    localparam int unsigned TAG_W = 4;
`ifdef MUL16_SEQ_MAC_EN
    localparam bit MacEn = 1'b1;
`else
    localparam bit MacEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic [TAG_W-1:0] in_tag;
`ifdef MUL16_SEQ_MAC_EN
    logic             in_acc;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_p;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    logic [31:0] prev_p = '0;  // model of the last completed product

    always #5 clk = ~clk;

    mul16_seq_ctrl #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
`ifdef MUL16_SEQ_MAC_EN
        .in_acc    (in_acc),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input bit acc);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        if (MacEn && acc) p = p + prev_p;
        return p;
    endfunction

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) check_val("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [TAG_W-1:0] tag, input bit acc);
        int g;
        g = 0;
        while (!in_ready && g < 20) begin
            tick();
            g++;
        end
        check_val("in_ready_before_send", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
`ifdef MUL16_SEQ_MAC_EN
        in_acc   = acc;
`else
        if (acc) begin end
`endif
        tick();
        in_valid = 1'b0;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
        in_tag   = TAG_W'($urandom);
    endtask

    task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [TAG_W-1:0] tag, input bit acc, input int hold);
        logic [31:0] exp;
        int n;
        exp = model(a, b, acc);
        send(a, b, tag, acc);
        wait_valid(n);
        prev_p = exp;
        check_val({name, "_latency"}, 64'(n), 64'd4);
        check_val({name, "_p"}, 64'(out_p), 64'(exp));
        check_val({name, "_tag"}, 64'(out_tag), 64'(tag));
        if (hold > 0) begin
            out_ready = 1'b0;
            repeat (hold) begin
                tick();
                check_val({name, "_hold_valid"}, 64'(out_valid), 64'd1);
                check_val({name, "_hold_p"}, 64'(out_p), 64'(exp));
            end
            out_ready = 1'b1;
        end
        tick();
        check_val({name, "_taken"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int n1, n2;
        logic [15:0] ra, rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
`ifdef MUL16_SEQ_MAC_EN
        in_acc    = 1'b0;
`endif
        out_ready = 1'b1;
        repeat (2) tick();
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_p", 64'(out_p), 64'd0);
        check_val("rst_out_tag", 64'(out_tag), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        tick();

        // Reset mid-operation
        send(16'h1234, 16'h5678, 4'h5, 1'b0);
        tick();
        tick();
        check_val("midrst_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        prev_p = '0;
        check_val("midrst_out_valid", 64'(out_valid), 64'd0);
        check_val("midrst_out_p", 64'(out_p), 64'd0);
        check_val("midrst_in_ready", 64'(in_ready), 64'd1);
        check_val("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Basic and corners
        do_op("basic", 16'h1234, 16'h5678, 4'h3, 1'b0, 0);
        check_val("basic_const", 64'(prev_p), 64'h06260060);
        do_op("ffff", 16'hFFFF, 16'hFFFF, 4'h1, 1'b0, 0);
        check_val("ffff_const", 64'(prev_p), 64'hFFFE0001);
        do_op("c0100", 16'h0100, 16'h0100, 4'h2, 1'b0, 1);
        do_op("zero", 16'h0000, 16'hBEEF, 4'h4, 1'b0, 0);
        do_op("c00ff", 16'h00FF, 16'hFF00, 4'h7, 1'b0, 2);
        check_val("c00ff_const", 64'(prev_p), 64'h00FE0100);

        // Backpressure: held result, second request refused
        send(16'hABCD, 16'h1357, 4'h9, 1'b0);
        wait_valid(n1);
        check_val("bp_p", 64'(out_p), 64'(model(16'hABCD, 16'h1357, 1'b0)));
        prev_p = out_p;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 16'h0002;
        in_b      = 16'h0003;
        in_tag    = 4'hC;
        repeat (10) begin
            tick();
            check_val("bp_hold_p", 64'(out_p), 64'(32'hABCD * 32'h1357));
            check_val("bp_hold_tag", 64'(out_tag), 64'h9);
            check_val("bp_in_ready", 64'(in_ready), 64'd0);
            check_val("bp_hold_valid", 64'(out_valid), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check_val("bp_released", 64'(out_valid), 64'd0);
        check_val("bp_not_accepted", 64'(busy), 64'd0);

        // Back-to-back with in_valid held high
`ifdef MUL16_SEQ_MAC_EN
        in_acc = 1'b0;
`endif
        in_valid = 1'b1;
        in_a     = 16'd3;
        in_b     = 16'd5;
        in_tag   = 4'h1;
        tick();
        in_a   = 16'd7;
        in_b   = 16'd9;
        in_tag = 4'h2;
        wait_valid(n1);
        check_val("b2b_lat1", 64'(n1), 64'd4);
        check_val("b2b_p1", 64'(out_p), 64'd15);
        check_val("b2b_tag1", 64'(out_tag), 64'h1);
        check_val("b2b_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check_val("b2b_accepted_busy", 64'(busy), 64'd1);
        check_val("b2b_valid_drop", 64'(out_valid), 64'd0);
        wait_valid(n2);
        check_val("b2b_spacing", 64'(n2 + 1), 64'd5);
        check_val("b2b_p2", 64'(out_p), 64'd63);
        check_val("b2b_tag2", 64'(out_tag), 64'h2);
        prev_p = 32'd63;
        tick();

`ifdef MUL16_SEQ_MAC_EN
        do_op("mac0", 16'd2, 16'd3, 4'h1, 1'b0, 0);
        check_val("mac0_const", 64'(out_p), 64'd6);
        do_op("mac1", 16'd4, 16'd5, 4'h2, 1'b1, 0);
        check_val("mac1_const", 64'(prev_p), 64'h1A);
        do_op("mac2", 16'hFFFF, 16'hFFFF, 4'h3, 1'b1, 0);
        check_val("mac2_const", 64'(prev_p), 64'hFFFE001B);
        do_op("mac3", 16'hFFFF, 16'hFFFF, 4'h4, 1'b1, 0);
        check_val("mac3_const", 64'(prev_p), 64'hFFFC001C);
`endif

        // Randomized operations with random backpressure
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 8 == 0) ra = 16'hFFFF;
            if (i % 8 == 1) rb = 16'h0000;
            do_op("rand", ra, rb, TAG_W'($urandom), bit'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul16_seq_ctrl.md
Name: mul16_seq_ctrl

Overview:
- Sequential 16x16 unsigned multiplier controller.
- Time-shares a single instance of the existing 8x8 array multiplier core (multi_8) over four cycles, one 8x8 partial product per cycle, and accumulates into a 32-bit result.
- Valid/ready handshake on input and output; sits between the operand source and any consumer that needs products wider than the 8x8 core provides.

Parameters:
- TAG_W, 4, width of the opaque tag carried with each operation from input to output.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair
- in_a  input  16  multiplicand, unsigned
- in_b  input  16  multiplier, unsigned
- in_tag  input  TAG_W  tag returned with the result
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_p  output  32  product
- out_tag  output  TAG_W  tag of this result
- busy  output  1  high in MUL state

Behaviour:
- Reset (async, rst=1): state=IDLE, step=0, acc=0, out_p=0, out_tag=0, out_valid=0, busy=0. Any in-flight operation is discarded.
- States:
  - IDLE: in_ready=1.
  - MUL: step counter 0..3, busy=1, in_ready=0.
  - DONE: out_valid=1.
- Accept: on an edge with in_valid && in_ready, latch a/b/tag, clear acc (or load the MAC base, see Optional Feature), set step=0, go to MUL.
- MUL step schedule. Core operands are muxed from the latched halves; each edge adds one zero-extended 16-bit core product to acc:
  - step 0: a[7:0]*b[7:0], shift 0
  - step 1: a[15:8]*b[7:0], shift 8
  - step 2: a[7:0]*b[15:8], shift 8
  - step 3: a[15:8]*b[15:8], shift 16
- Step 3 edge moves to DONE.
- Arithmetic: acc is 32 bits. Unsigned sum never exceeds 0xFFFE0001, so no overflow in plain mode.
- Latency: out_valid rises exactly 4 clock edges after the accepting edge. out_p = acc; out_tag = latched tag.
- DONE: out_p and out_tag are held stable while out_valid && !out_ready.
  - On an edge with out_ready=1: return to IDLE.
  - Back-to-back: in_ready = IDLE || (DONE && out_ready). If in_valid is also high on that edge, the new op is accepted and the next state is MUL. Sustained throughput is 1 op per 5 cycles.
- Input latched once: changes on in_a/in_b/in_tag after acceptance have no effect.
- in_valid while not ready: ignored, no state change. The source must hold its data.
- out_valid stays high until taken; the block never drops a result.
- Reset mid-MUL or mid-DONE: immediate return to IDLE with all outputs 0.

Optional Feature:
- Macro MUL16_SEQ_MAC_EN.
- Defined:
  - Adds input port in_acc (1 bit, sampled with in_a on accept).
  - in_acc=1: acc starts from the previous completed out_p. The result is a*b + previous out_p, mod 2^32 (wraps silently).
  - in_acc=0: acc starts at 0.
  - Reset clears the previous-result register to 0.
- Undefined: no in_acc port; acc always starts at 0.

Decomposition:
- Shared package mul16_pkg holds:
  - state enum (IDLE, MUL, DONE)
  - constants PROD_W=32, HALF_W=8
  - step-to-shift constants (0, 8, 8, 16)
- One sub-module: the existing multi_8 core, instantiated once, purely combinational. All control, operand muxing and accumulation live in mul16_seq_ctrl.

Test Plan:
- Reset mid-operation: accept 0x1234*0x5678, assert rst after 2 cycles -> out_valid=0, out_p=0, in_ready=1 immediately. A fresh op then completes correctly.
- Basic: in_a=0x1234, in_b=0x5678, tag=0x3, out_ready=1 -> out_valid exactly 4 edges after accept, out_p=0x06260060, out_tag=0x3.
- Corners:
  - 0xFFFF*0xFFFF -> 0xFFFE0001.
  - 0x0100*0x0100 -> 0x00010000.
  - 0x0000*0xBEEF -> 0x00000000.
  - 0x00FF*0xFF00 -> 0x00FE0100.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_p and out_tag stable, in_ready=0, and a second in_valid is not accepted. Raising out_ready completes the handshake.
- Back-to-back: in_valid held high with ops 3*5 (tag 1) then 7*9 (tag 2), out_ready=1 -> results 15 and 63 in order, out_valid pulses 5 cycles apart, second op accepted on the same edge the first result is taken.
- With MUL16_SEQ_MAC_EN: 2*3 with in_acc=0 -> 6, then 4*5 with in_acc=1 -> 0x1A. Then 0xFFFF*0xFFFF with in_acc=1 twice -> 0xFFFE001B, then 0xFFFC001C (wraps mod 2^32).
